if_fetch_unit: RTL

//   Instruction-fetch stage that drives the IF/ID pipeline register. It owns the PC
//   and issues one-outstanding requests to instruction memory (variable latency).

---
 rtl/if_fetch_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding imem requests and
// buffers returned words in a DEPTH-entry {pc+4, inst} queue. Optional IFU_STATS_EN adds counters.
module if_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
`ifdef IFU_STATS_EN
  ,
  output logic [31:0] bubble_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_addr;
  logic          r_req;
  logic [31:0]   r_q_pc   [DEPTH];
  logic [31:0]   r_q_inst [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic [AW:0]   w_count_nxt;
  logic          w_space;
  logic [31:0]   w_target;
  logic [31:0]   w_addr_inc;
  logic [31:0]   w_redir;

  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid & ~stall_i & ~flush_i;
  assign w_push      = (r_state == S_REQ) & imem_ack_i & ~flush_i;
  assign w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
  // Space left for one more request once this cycle's push/pop have settled
  assign w_space     = (w_count_nxt < (AW+1)'(DEPTH));
  assign w_target    = {target_i[31:2], 2'b00};
  assign w_addr_inc  = r_addr + 32'd4;
  // In DROP the saved redirect target lives in r_fetch_pc; a new flush overrides it
  assign w_redir     = flush_i ? w_target : r_fetch_pc;

  assign imem_req_o  = r_req;
  assign imem_addr_o = r_addr;
  assign valid_o     = w_valid;
  assign pc_o        = w_valid ? r_q_pc[r_rd_ptr]   : 32'h0;
  assign inst_o      = w_valid ? r_q_inst[r_rd_ptr] : 32'h0;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= w_addr_inc;
      r_q_inst[r_wr_ptr] <= imem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush_i) begin
            r_fetch_pc <= w_target;
          end else if (start_i && w_space) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_addr  <= r_fetch_pc;
          end
        end
        S_REQ: begin
          if (imem_ack_i) begin
            if (flush_i) begin
              r_fetch_pc <= w_target;
              if (start_i) begin
                r_addr <= w_target;
              end else begin
                r_state <= S_IDLE;
                r_req   <= 1'b0;
              end
            end else begin
              r_fetch_pc <= w_addr_inc;
              if (start_i && w_space) begin
                r_addr <= w_addr_inc;
              end else begin
                r_state <= S_IDLE;
                r_req   <= 1'b0;
              end
            end
          end else if (flush_i) begin
            r_fetch_pc <= w_target;
            r_state    <= S_DROP;
          end
        end
        S_DROP: begin
          r_fetch_pc <= w_redir;
          if (imem_ack_i) begin
            if (start_i) begin
              r_state <= S_REQ;
              r_addr  <= w_redir;
            end else begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFU_STATS_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bubble_cnt <= 32'h0;
      r_flush_cnt  <= 32'h0;
    end else begin
      if (!w_valid && !stall_i && start_i && (r_bubble_cnt != 32'hFFFF_FFFF))
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (flush_i && (r_flush_cnt != 32'hFFFF_FFFF))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
  assign flush_cnt_o  = r_flush_cnt;
`endif

endmodule
